// File: rtl/cnt_mmss_down_if.sv
// Control, preset and display bundle of the mm:ss countdown timer.
// master drives controls/preset and observes the count; slave is the timer.
interface cnt_mmss_down_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       stop;
    logic [2:0] set_mup;
    logic [3:0] set_mlow;
    logic [2:0] set_sup;
    logic [3:0] set_slow;
    logic [2:0] min_up;
    logic [3:0] min_low;
    logic [2:0] sec_up;
    logic [3:0] sec_low;
    logic       running;
    logic       done;
    logic       expire;

    modport master (
        output tick, load, start, stop,
        output set_mup, set_mlow, set_sup, set_slow,
        input  min_up, min_low, sec_up, sec_low,
        input  running, done, expire
    );

    modport slave (
        input  tick, load, start, stop,
        input  set_mup, set_mlow, set_sup, set_slow,
        output min_up, min_low, sec_up, sec_low,
        output running, done, expire
    );
endinterface

// File: rtl/cnt_mmss_down.sv
// mm:ss BCD countdown timer: load/start/stop control, one decrement per tick in RUN, expiry flag.
// Optional AUTORELOAD_EN: expiry reloads the preset and keeps running instead of entering DONE.
module cnt_mmss_down #(
    parameter logic [7:0] PRESET_MIN = 8'h05,
    parameter logic [7:0] PRESET_SEC = 8'h00
) (
    input  logic             CLK,
    input  logic             RST,
    cnt_mmss_down_if.slave   bus
);

    typedef struct packed {
        logic [2:0] mu;
        logic [3:0] ml;
        logic [2:0] su;
        logic [3:0] sl;
    } mmss_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] clamp_up(input logic [3:0] d);
        return (d > 4'd5) ? 3'd5 : d[2:0];
    endfunction

    function automatic logic [3:0] clamp_low(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    localparam mmss_t RST_PRESET = {clamp_up(PRESET_MIN[7:4]), clamp_low(PRESET_MIN[3:0]),
                                    clamp_up(PRESET_SEC[7:4]), clamp_low(PRESET_SEC[3:0])};
    localparam mmss_t ONE_SEC    = {3'd0, 4'd0, 3'd0, 4'd1};

    state_t r_state, w_state_nxt;
    mmss_t  r_count, w_count_nxt;
    mmss_t  r_preset, w_preset_nxt;
    logic   r_expire, w_expire_nxt;

    mmss_t  w_set;
    mmss_t  w_dec;
    logic   w_zero;
    logic   w_last;

    assign w_set  = {clamp_up({1'b0, bus.set_mup}), clamp_low(bus.set_mlow),
                     clamp_up({1'b0, bus.set_sup}), clamp_low(bus.set_slow)};
    assign w_zero = (r_count == '0);
    assign w_last = (r_count == ONE_SEC);

    // BCD borrow chain; saturates at 00:00 so the count can never wrap.
    always_comb begin
        w_dec = r_count;
        if (!w_zero) begin
            if (r_count.sl != 4'd0) begin
                w_dec.sl = r_count.sl - 4'd1;
            end else begin
                w_dec.sl = 4'd9;
                if (r_count.su != 3'd0) begin
                    w_dec.su = r_count.su - 3'd1;
                end else begin
                    w_dec.su = 3'd5;
                    if (r_count.ml != 4'd0) begin
                        w_dec.ml = r_count.ml - 4'd1;
                    end else begin
                        w_dec.ml = 4'd9;
                        w_dec.mu = r_count.mu - 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_preset_nxt = r_preset;
        w_expire_nxt = 1'b0;

        if (bus.load) begin
            w_preset_nxt = w_set;
            w_count_nxt  = w_set;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // stop beats start, so a simultaneous pair leaves us idle
                    if (!bus.stop && bus.start) begin
                        if (w_zero) begin
                            w_state_nxt  = S_DONE;
                            w_expire_nxt = 1'b1;
                        end else begin
                            w_state_nxt  = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.tick && w_last) begin
                        w_expire_nxt = 1'b1;
`ifdef AUTORELOAD_EN
                        w_count_nxt  = r_preset;
                        w_state_nxt  = S_RUN;
`else
                        w_count_nxt  = w_dec;
                        w_state_nxt  = S_DONE;
`endif
                    end else begin
                        if (bus.tick) begin
                            w_count_nxt = w_dec;
                        end
                        if (bus.stop) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.stop) begin
                        w_state_nxt = S_IDLE;
                        w_count_nxt = r_preset;
                    end else if (bus.start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.start || bus.stop) begin
                        w_state_nxt = S_IDLE;
                        w_count_nxt = r_preset;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = r_preset;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_count  <= RST_PRESET;
            r_preset <= RST_PRESET;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_preset <= w_preset_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    assign bus.min_up  = r_count.mu;
    assign bus.min_low = r_count.ml;
    assign bus.sec_up  = r_count.su;
    assign bus.sec_low = r_count.sl;
    assign bus.running = (r_state == S_RUN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.expire  = r_expire;

endmodule

// File: tb/tb_cnt_mmss_down.sv
// Self-checking bench for cnt_mmss_down: directed scenarios plus random control traffic
// against a reference model that tracks the count as plain seconds.
module tb_cnt_mmss_down;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    cnt_mmss_down_if bus();

    cnt_mmss_down dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int n_vec = 0;
    int n_err = 0;

    int   m_state;
    int   m_cnt;
    int   m_pre;
    logic m_exp;

    function automatic int lim(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic int set_secs();
        int mm, ss;
        mm = lim(int'(bus.set_mup), 5) * 10 + lim(int'(bus.set_mlow), 9);
        ss = lim(int'(bus.set_sup), 5) * 10 + lim(int'(bus.set_slow), 9);
        return mm * 60 + ss;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_time();
        return bus.min_up * 1000 + bus.min_low * 100 + bus.sec_up * 10 + bus.sec_low;
    endfunction

    task automatic model_reset();
        m_pre   = 5 * 60;
        m_cnt   = m_pre;
        m_state = M_IDLE;
        m_exp   = 1'b0;
    endtask

    // Evaluated with the input values that were present at the clock edge.
    task automatic model_edge();
        m_exp = 1'b0;
        if (bus.load) begin
            m_pre   = set_secs();
            m_cnt   = m_pre;
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (!bus.stop && bus.start) begin
                    if (m_cnt == 0) begin
                        m_state = M_DONE;
                        m_exp   = 1'b1;
                    end else begin
                        m_state = M_RUN;
                    end
                end
                M_RUN: if (bus.tick && m_cnt == 1) begin
                    m_exp = 1'b1;
`ifdef AUTORELOAD_EN
                    m_cnt = m_pre;
`else
                    m_cnt   = 0;
                    m_state = M_DONE;
`endif
                end else begin
                    if (bus.tick && m_cnt > 0) m_cnt = m_cnt - 1;
                    if (bus.stop) m_state = M_PAUSE;
                end
                M_PAUSE: if (bus.stop) begin
                    m_state = M_IDLE;
                    m_cnt   = m_pre;
                end else if (bus.start) begin
                    m_state = M_RUN;
                end
                default: if (bus.start || bus.stop) begin
                    m_state = M_IDLE;
                    m_cnt   = m_pre;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        int mins, secs;
        mins = m_cnt / 60;
        secs = m_cnt % 60;
        chk({tag, ".time"}, obs_time(), (mins / 10) * 1000 + (mins % 10) * 100 + (secs / 10) * 10 + secs % 10);
        chk({tag, ".running"}, bus.running, m_state == M_RUN);
        chk({tag, ".done"}, bus.done, m_state == M_DONE);
        chk({tag, ".expire"}, bus.expire, m_exp);
    endtask

    task automatic step(input logic tk, input logic ld, input logic st, input logic sp);
        bus.tick  = tk;
        bus.load  = ld;
        bus.start = st;
        bus.stop  = sp;
        @(posedge CLK);
        model_edge();
        #1;
        check_all("step");
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_time(input int mu, input int ml, input int su, input int sl);
        bus.set_mup  = mu[2:0];
        bus.set_mlow = ml[3:0];
        bus.set_sup  = su[2:0];
        bus.set_slow = sl[3:0];
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        RST       = 1'b1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.set_mup  = '0;
        bus.set_mlow = '0;
        bus.set_sup  = '0;
        bus.set_slow = '0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.const", obs_time(), 500);
        RST = 1'b0;

        // borrow chain across seconds and minutes
        load_time(1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start.running", bus.running, 1'b1);
        ticks(1);
        chk("borrow.first", obs_time(), 959);
        ticks(60);
        chk("borrow.minute", obs_time(), 859);

        // expiry
        load_time(0, 0, 0, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
`ifndef AUTORELOAD_EN
        chk("expiry.time", obs_time(), 0);
        chk("expiry.done", bus.done, 1'b1);
        chk("expiry.pulse", bus.expire, 1'b1);
        ticks(1);
        chk("expiry.pulse_end", bus.expire, 1'b0);
        chk("expiry.hold", obs_time(), 0);
`endif

        // pause and clear
        load_time(0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("pause.run", obs_time(), 57);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2);
        chk("pause.hold", obs_time(), 57);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear.time", obs_time(), 100);
        chk("clear.idle", bus.running, 1'b0);

        // clamp with load beating start+stop, then start+stop together
        bus.set_mup = 3'd7; bus.set_mlow = 4'hF; bus.set_sup = 3'd6; bus.set_slow = 4'hC;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clamp.time", obs_time(), 5959);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("startstop.idle", bus.running, 1'b0);

        // start with a zero preset
        load_time(0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("zero.done", bus.done, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // tick+stop in RUN, then expiry with a stop on the same edge
        load_time(0, 0, 0, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("tickstop.time", obs_time(), 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("expstop.pulse", bus.expire, 1'b1);

        // load wins over a simultaneous expiring tick
        load_time(0, 0, 0, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        bus.set_slow = 4'd7;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("loadprio.expire", bus.expire, 1'b0);

`ifdef AUTORELOAD_EN
        load_time(0, 0, 0, 3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("reload.time", obs_time(), 3);
        chk("reload.running", bus.running, 1'b1);
        chk("reload.done", bus.done, 1'b0);
        chk("reload.pulse", bus.expire, 1'b1);
`endif

        // random control traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.set_mup  = 3'($urandom_range(0, 7));
                    bus.set_mlow = 4'($urandom_range(0, 15));
                    bus.set_sup  = 3'($urandom_range(0, 7));
                    bus.set_slow = 4'($urandom_range(0, 15));
                end else begin
                    bus.set_mup  = 3'd0;
                    bus.set_mlow = 4'($urandom_range(0, 1));
                    bus.set_sup  = 3'($urandom_range(0, 1));
                    bus.set_slow = 4'($urandom_range(0, 9));
                end
                step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0,
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0));
            end
        end

        // asynchronous reset mid-count
        load_time(0, 2, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5);
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        #2;
        RST = 1'b0;
        ticks(2);
        chk("midrst.idle", obs_time(), 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
